// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access engine feeding the MEM/WB pipeline register.
// Non-memory instructions pass straight through combinationally. Loads and
// stores are checked first. A legal access is latched and issued to data
// memory as a registered req/ack transaction. The upstream stages are frozen
// until the memory acknowledges or the access times out.
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-low reset
//   i_Valid                     EX/MEM holds a real instruction
//   i_Sig_Write_Back_Enable     instruction writes the register file
//   i_Sig_Memory_Read_Enable    load
//   i_Sig_Memory_Write_Enable   store
//   i_ALU_Result                byte address (loads/stores) or ALU result
//   i_Store_Value               store data
//   i_Destination               destination register
//   o_Mem_Req/We/Addr/Wdata     registered request to data memory (word address)
//   i_Mem_Ack, i_Mem_Rdata      memory completion; read data valid with ack
//   o_Sig_Write_Back_Enable,
//   o_Sig_Memory_Read_Enable,
//   o_ALU_Result,
//   o_Memory_Read_Value,
//   o_Destination               completed instruction presented to MEM/WB
//   o_Freeze                    stall IF/ID/EX and EX/MEM
//   o_Mem_Error                 sticky error (misaligned / out of range /
//                               rd&wr / timeout), cleared only by reset
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BASE      = 1024,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Valid,
    input  logic                  i_Sig_Write_Back_Enable,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    input  logic [DATA_WIDTH-1:0] i_Store_Value,
    input  logic [3:0]            i_Destination,
    output logic                  o_Mem_Req,
    output logic                  o_Mem_We,
    output logic [DATA_WIDTH-1:0] o_Mem_Addr,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic                  i_Mem_Ack,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    output logic                  o_Sig_Write_Back_Enable,
    output logic                  o_Sig_Memory_Read_Enable,
    output logic [DATA_WIDTH-1:0] o_ALU_Result,
    output logic [DATA_WIDTH-1:0] o_Memory_Read_Value,
    output logic [3:0]            o_Destination,
    output logic                  o_Freeze,
    output logic                  o_Mem_Error
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] BASE     = DATA_WIDTH'(ADDR_BASE);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic                    req_reg, req_next;
    logic                    we_reg, we_next;
    logic [DATA_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    error_reg, error_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    wb_reg, wb_next;
    logic                    rd_reg, rd_next;
    logic [DATA_WIDTH-1:0]   alu_reg, alu_next;
    logic [3:0]              dest_reg, dest_next;

    logic                    mem_op;
    logic                    illegal_op;

    assign mem_op     = i_Valid & (i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable);
    // Unsigned compare: anything below the data memory base is out of range.
    assign illegal_op = (i_ALU_Result[1:0] != 2'b00)
                      | (i_ALU_Result < BASE)
                      | (i_Sig_Memory_Read_Enable & i_Sig_Memory_Write_Enable);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            error_reg <= 1'b0;
            cnt_reg   <= '0;
            wb_reg    <= 1'b0;
            rd_reg    <= 1'b0;
            alu_reg   <= '0;
            dest_reg  <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            error_reg <= error_next;
            cnt_reg   <= cnt_next;
            wb_reg    <= wb_next;
            rd_reg    <= rd_next;
            alu_reg   <= alu_next;
            dest_reg  <= dest_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        error_next = error_reg;
        cnt_next   = cnt_reg;
        wb_next    = wb_reg;
        rd_next    = rd_reg;
        alu_next   = alu_reg;
        dest_next  = dest_reg;

        o_Sig_Write_Back_Enable  = 1'b0;
        o_Sig_Memory_Read_Enable = 1'b0;
        o_ALU_Result             = '0;
        o_Memory_Read_Value      = '0;
        o_Destination            = '0;
        o_Freeze                 = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!mem_op) begin
                    // Zero-latency pass-through for non-memory instructions.
                    o_Sig_Write_Back_Enable = i_Sig_Write_Back_Enable & i_Valid;
                    o_ALU_Result            = i_ALU_Result;
                    o_Destination           = i_Destination;
                end else if (illegal_op) begin
                    // Completes at once as a no-write instruction and flags the error.
                    o_ALU_Result  = i_ALU_Result;
                    o_Destination = i_Destination;
                    error_next    = 1'b1;
                end else begin
                    // Accept: latch the instruction, issue the request next edge.
                    o_Freeze   = 1'b1;
                    wb_next    = i_Sig_Write_Back_Enable;
                    rd_next    = i_Sig_Memory_Read_Enable;
                    alu_next   = i_ALU_Result;
                    dest_next  = i_Destination;
                    req_next   = 1'b1;
                    we_next    = i_Sig_Memory_Write_Enable;
                    addr_next  = (i_ALU_Result - BASE) >> 2;
                    wdata_next = i_Sig_Memory_Write_Enable ? i_Store_Value : '0;
                    cnt_next   = '0;
                    state_next = ACCESS;
                end
            end

            ACCESS: begin
                if (i_Mem_Ack) begin
                    o_Sig_Write_Back_Enable  = wb_reg;
                    o_Sig_Memory_Read_Enable = rd_reg;
                    o_ALU_Result             = alu_reg;
                    o_Destination            = dest_reg;
                    o_Memory_Read_Value      = rd_reg ? i_Mem_Rdata : '0;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    // Timeout: retire the instruction without writing back.
                    o_ALU_Result  = alu_reg;
                    o_Destination = dest_reg;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    cnt_next   = '0;
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    o_Freeze = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase

        // Reset holds the MEM/WB side quiet and never stalls the pipe.
        if (!reset) begin
            o_Sig_Write_Back_Enable  = 1'b0;
            o_Sig_Memory_Read_Enable = 1'b0;
            o_ALU_Result             = '0;
            o_Memory_Read_Value      = '0;
            o_Destination            = '0;
            o_Freeze                 = 1'b0;
        end
    end

    assign o_Mem_Req   = req_reg;
    assign o_Mem_We    = we_reg;
    assign o_Mem_Addr  = addr_reg;
    assign o_Mem_Wdata = wdata_reg;
    assign o_Mem_Error = error_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed scenarios with literal expectations, followed by randomized
// traffic. A transaction-level model (outstanding access record, wait count,
// sticky error) predicts every output on every cycle; a single compare
// process at the falling edge checks the DUT against it.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int DW   = 32;
    localparam int BASE = 1024;
    localparam int TMO  = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_Valid = 1'b0;
    logic          i_wb = 1'b0;
    logic          i_rd = 1'b0;
    logic          i_wr = 1'b0;
    logic [DW-1:0] i_alu = '0;
    logic [DW-1:0] i_store = '0;
    logic [3:0]    i_dest = '0;
    logic          i_ack = 1'b0;
    logic [DW-1:0] i_rdata = '0;

    logic          o_Mem_Req;
    logic          o_Mem_We;
    logic [DW-1:0] o_Mem_Addr;
    logic [DW-1:0] o_Mem_Wdata;
    logic          o_wb;
    logic          o_rd;
    logic [DW-1:0] o_alu;
    logic [DW-1:0] o_val;
    logic [3:0]    o_dest;
    logic          o_Freeze;
    logic          o_Mem_Error;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_WIDTH     (DW),
        .ADDR_BASE      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_Valid                   (i_Valid),
        .i_Sig_Write_Back_Enable   (i_wb),
        .i_Sig_Memory_Read_Enable  (i_rd),
        .i_Sig_Memory_Write_Enable (i_wr),
        .i_ALU_Result              (i_alu),
        .i_Store_Value             (i_store),
        .i_Destination             (i_dest),
        .o_Mem_Req                 (o_Mem_Req),
        .o_Mem_We                  (o_Mem_We),
        .o_Mem_Addr                (o_Mem_Addr),
        .o_Mem_Wdata               (o_Mem_Wdata),
        .i_Mem_Ack                 (i_ack),
        .i_Mem_Rdata               (i_rdata),
        .o_Sig_Write_Back_Enable   (o_wb),
        .o_Sig_Memory_Read_Enable  (o_rd),
        .o_ALU_Result              (o_alu),
        .o_Memory_Read_Value       (o_val),
        .o_Destination             (o_dest),
        .o_Freeze                  (o_Freeze),
        .o_Mem_Error               (o_Mem_Error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          model_on = 1'b0;
    bit          m_busy   = 1'b0;   // an access is outstanding at memory
    bit          m_err    = 1'b0;
    int          m_wait   = 0;      // access cycles already spent without ack
    bit          m_wb, m_rd, m_wr;
    logic [31:0] m_alu, m_word, m_wdata;
    logic [3:0]  m_dest;

    always @(negedge clk) begin : cmp
        bit          e_wb, e_rd, e_fz, e_ad;
        logic [31:0] e_alu, e_val;
        logic [3:0]  e_dest;
        bit          memop, bad;

        if (model_on) begin
            chk1("req", o_Mem_Req, m_busy);
            chk1("error", o_Mem_Error, m_err);
            if (m_busy) begin
                chk1("we", o_Mem_We, m_wr);
                chk("addr", o_Mem_Addr, m_word);
                chk("wdata", o_Mem_Wdata, m_wdata);
            end
        end

        e_wb = 0; e_rd = 0; e_fz = 0; e_ad = 1; e_alu = 0; e_val = 0; e_dest = 0;
        memop = i_Valid && (i_rd || i_wr);
        bad   = (i_alu % 4 != 0) || (i_alu < BASE) || (i_rd && i_wr);

        if (!reset) begin
            m_busy = 0; m_err = 0; m_wait = 0;
        end else if (!m_busy) begin
            if (!memop) begin
                e_wb = i_wb && i_Valid; e_alu = i_alu; e_dest = i_dest;
            end else if (bad) begin
                e_alu = i_alu; e_dest = i_dest; m_err = 1;
            end else begin
                e_fz = 1;
                m_busy = 1; m_wait = 0;
                m_wb = i_wb; m_rd = i_rd; m_wr = i_wr;
                m_alu = i_alu; m_dest = i_dest;
                m_word = (i_alu - BASE) / 4;
                m_wdata = i_wr ? i_store : 32'h0;
            end
        end else if (i_ack) begin
            e_wb = m_wb; e_rd = m_rd; e_alu = m_alu; e_dest = m_dest;
            e_val = m_rd ? i_rdata : 32'h0;
            m_busy = 0;
        end else if (m_wait == TMO - 1) begin
            e_ad = 0;               // only WB/MemRd/value/freeze are defined here
            m_busy = 0; m_err = 1;
        end else begin
            e_fz = 1;
            m_wait++;
        end

        if (model_on) begin
            chk1("freeze", o_Freeze, e_fz);
            chk1("wb_en", o_wb, e_wb);
            chk1("mem_rd", o_rd, e_rd);
            chk("read_value", o_val, e_val);
            if (e_ad) begin
                chk("alu_out", o_alu, e_alu);
                chk("dest", 32'(o_dest), 32'(e_dest));
            end
        end
        if (!reset) model_on = 1;
    end

    // Drive one cycle: inputs change 1 ns after the rising edge; the task
    // returns 1 ns after the falling edge so callers can sample outputs.
    task automatic drv(input logic rst, input logic v, input logic wb, input logic rd,
                       input logic wr, input logic [31:0] alu, input logic [31:0] st,
                       input logic [3:0] dest, input logic ack, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        reset = rst; i_Valid = v; i_wb = wb; i_rd = rd; i_wr = wr;
        i_alu = alu; i_store = st; i_dest = dest; i_ack = ack; i_rdata = rdata;
        #5;
    endtask

    task automatic idle();
        drv(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    endtask

    task automatic rst_cycle();
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    endtask

    initial begin
        int fz_cnt, req_cnt, lat;
        bit seen;
        logic v, wb, rd, wr, ack, rst;
        logic [31:0] alu, st;

        rst_cycle();
        rst_cycle();
        chk1("reset_req", o_Mem_Req, 0);
        chk1("reset_freeze", o_Freeze, 0);

        // 1: pass-through
        drv(1, 1, 1, 0, 0, 32'h000000AB, 32'h0, 4'b1010, 0, 32'h0);
        $display("T1 pass-through alu=%h dest=%b", o_alu, o_dest);
        chk1("t1_wb", o_wb, 1);
        chk("t1_alu", o_alu, 32'h000000AB);
        chk("t1_dest", 32'(o_dest), 32'hA);
        chk1("t1_freeze", o_Freeze, 0);
        idle();
        chk1("t1_req", o_Mem_Req, 0);

        // 2: load, ack 3 cycles after Req rises; inputs churn meanwhile
        drv(1, 1, 1, 1, 0, 32'h00000408, 32'hDEADBEEF, 4'h3, 0, 32'h0);
        fz_cnt = int'(o_Freeze);
        chk1("t2_accept_wb", o_wb, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0, 1, 32'h00000500, 32'h55555555, 4'hF, 0, 32'h12345678);
            fz_cnt += int'(o_Freeze);
            chk1("t2_req", o_Mem_Req, 1);
            chk("t2_addr", o_Mem_Addr, 32'h2);
            chk1("t2_we", o_Mem_We, 0);
        end
        drv(1, 1, 0, 0, 1, 32'h00000500, 32'h55555555, 4'hF, 1, 32'h98765432);
        $display("T2 load value=%h freeze_cycles=%0d", o_val, fz_cnt);
        chk1("t2_freeze_rel", o_Freeze, 0);
        chk1("t2_wb", o_wb, 1);
        chk1("t2_memrd", o_rd, 1);
        chk("t2_value", o_val, 32'h98765432);
        chk("t2_alu", o_alu, 32'h00000408);
        chk("t2_freeze_cycles", fz_cnt, 4);
        idle();
        chk1("t2_req_drop", o_Mem_Req, 0);

        // 3: store acked in first access cycle
        drv(1, 1, 0, 0, 1, 32'h00000400, 32'h11223344, 4'h5, 0, 32'h0);
        chk1("t3_accept_freeze", o_Freeze, 1);
        drv(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hFFFFFFFF);
        $display("T3 store addr=%h wdata=%h", o_Mem_Addr, o_Mem_Wdata);
        chk1("t3_we", o_Mem_We, 1);
        chk("t3_addr", o_Mem_Addr, 32'h0);
        chk("t3_wdata", o_Mem_Wdata, 32'h11223344);
        chk1("t3_freeze", o_Freeze, 0);
        chk("t3_value", o_val, 32'h0);
        idle();

        // 4: load, never acked
        drv(1, 1, 1, 1, 0, 32'h0000040C, 32'h0, 4'h7, 0, 32'h0);
        req_cnt = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (!o_Mem_Req) break;
            req_cnt++;
            if (!o_Freeze) begin
                seen = 1;
                chk1("t4_wb", o_wb, 0);
                chk1("t4_memrd", o_rd, 0);
            end
        end
        $display("T4 timeout req_cycles=%0d error=%b", req_cnt, o_Mem_Error);
        chk("t4_req_cycles", req_cnt, TMO);
        chk1("t4_completion_seen", seen, 1);
        chk1("t4_error", o_Mem_Error, 1);
        chk1("t4_freeze", o_Freeze, 0);

        // 5: misaligned load
        rst_cycle();
        drv(1, 1, 1, 1, 0, 32'h00000402, 32'h0, 4'h9, 0, 32'h0);
        chk1("t5_wb", o_wb, 0);
        chk1("t5_freeze", o_Freeze, 0);
        chk1("t5_error_now", o_Mem_Error, 0);
        idle();
        $display("T5 misaligned req=%b error=%b", o_Mem_Req, o_Mem_Error);
        chk1("t5_req", o_Mem_Req, 0);
        chk1("t5_error", o_Mem_Error, 1);

        // 6: reset in the middle of an access
        rst_cycle();
        drv(1, 1, 1, 1, 0, 32'h00000410, 32'h0, 4'h6, 0, 32'h0);
        idle();
        idle();
        drv(0, 1, 1, 0, 0, 32'h00000055, 32'h0, 4'h1, 0, 32'h0);
        chk1("t6_rst_freeze", o_Freeze, 0);
        chk1("t6_rst_wb", o_wb, 0);
        chk("t6_rst_alu", o_alu, 32'h0);
        drv(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hCAFEBABE);
        chk1("t6_req", o_Mem_Req, 0);
        chk1("t6_error", o_Mem_Error, 0);
        chk1("t6_memrd", o_rd, 0);
        drv(1, 1, 1, 1, 0, 32'h00000414, 32'h0, 4'h2, 0, 32'h0);
        drv(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0BADF00D);
        $display("T6 post-reset load addr=%h value=%h", o_Mem_Addr, o_val);
        chk("t6_addr", o_Mem_Addr, 32'h5);
        chk("t6_value", o_val, 32'h0BADF00D);
        chk("t6_dest", 32'(o_dest), 32'h2);

        // Randomized traffic
        lat = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 100) != 0;
            if (m_busy) begin
                if (m_wait == 0) lat = ($urandom % 6 == 0) ? 99 : int'($urandom % 6);
                ack = (m_wait == lat);
            end else begin
                ack = ($urandom % 4) == 0;
            end
            v  = ($urandom % 10) != 0;
            wb = $urandom % 2;
            rd = 0; wr = 0;
            alu = BASE + 4 * ($urandom % 16);
            st  = $urandom;
            case ($urandom % 10)
                0, 1:    alu = $urandom;
                2:       begin rd = 1; alu = alu + 1 + ($urandom % 3); end
                3:       begin wr = 1; alu = $urandom_range(0, BASE - 1); end
                4:       begin rd = 1; wr = 1; end
                5, 6, 7: rd = 1;
                default: wr = 1;
            endcase
            drv(rst, v, wb, rd, wr, alu, st, 4'($urandom), ack, $urandom);
            if (n % 500 == 0)
                $display("random cycle %0d req=%b freeze=%b err=%b", n, o_Mem_Req, o_Freeze, o_Mem_Error);
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
